// File: rtl/cdp_intp_pkg.sv
// cdp_intp_pkg: rounding modes, datapath width helpers and saturation limits for the CDP interpolator
package cdp_intp_pkg;
    typedef enum logic [1:0] {RND_FLOOR = 2'd0, RND_AWAY = 2'd1, RND_EVEN = 2'd2} rnd_mode_e;

    function automatic int mul_w(input int data_w, input int scale_w);
        return data_w + 1 + scale_w;
    endfunction

    // room for the largest left shift, so nothing overflows ahead of saturation
    function automatic int shr_ext_w(input int data_w, input int scale_w, input int shift_w);
        return mul_w(data_w, scale_w) + (1 << (shift_w - 1));
    endfunction

    function automatic int sum_w(input int ext_w, input int base_w);
        return (ext_w > base_w ? ext_w : base_w) + 1;
    endfunction

    localparam int MUL_W = mul_w(39, 17);
    localparam int SHR_EXT_W = shr_ext_w(39, 17, 6);
    localparam int SUM_W = sum_w(SHR_EXT_W, 17);

    function automatic logic [63:0] sat_max(input int out_w);
        return (64'd1 << (out_w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int out_w);
        return ~sat_max(out_w);
    endfunction
endpackage

// File: rtl/cdp_intp_lane_dp.sv
// cdp_intp_lane_dp: one lane of subtract, multiply, shift-round, add and saturate
module cdp_intp_lane_dp
    import cdp_intp_pkg::*;
#(
    parameter int DATA_W  = 39,
    parameter int SCALE_W = 17,
    parameter int SHIFT_W = 6,
    parameter int BASE_W  = 17,
    parameter int OUT_W   = 16
) (
    input  logic                      autosa_core_clk,
    input  logic                      autosa_core_rst,
    input  logic                      en0,
    input  logic                      en1,
    input  logic                      en2,
    input  logic signed [DATA_W-1:0]  x0,
    input  logic signed [DATA_W-1:0]  x1,
    input  logic signed [BASE_W-1:0]  base,
    input  logic signed [SCALE_W-1:0] scale,
    input  logic signed [SHIFT_W-1:0] shift,
    input  logic [1:0]                rnd_mode,
    output logic [OUT_W-1:0]          out_pd,
    output logic                      out_sat
);
    localparam int SUB_W = DATA_W + 1;
    localparam int M_W = mul_w(DATA_W, SCALE_W);
    localparam int E_W = shr_ext_w(DATA_W, SCALE_W, SHIFT_W);
    localparam int S_W = sum_w(E_W, BASE_W);
    localparam logic [63:0] MAXV = sat_max(OUT_W);
    localparam logic [63:0] MINV = sat_min(OUT_W);

    logic signed [SUB_W-1:0]   sub_q;
    logic signed [SCALE_W-1:0] scale_q;
    logic signed [BASE_W-1:0]  base0_q, base1_q;
    logic signed [SHIFT_W-1:0] shift0_q, shift1_q;
    logic signed [M_W-1:0]     mul_q;
    logic signed [E_W-1:0]     ext, shr, rnd;
    logic [E_W-1:0]            frac, half;
    logic [SHIFT_W-2:0]        rsh;
    logic [SHIFT_W:0]          lsh;
    logic                      inc, fits;
    logic signed [S_W-1:0]     sum;

    always_comb begin
        ext = E_W'(mul_q);
        rsh = shift1_q[SHIFT_W-2:0];
        lsh = -(SHIFT_W+1)'(shift1_q);
        shr = ext >>> rsh;
        frac = ext & ~({E_W{1'b1}} << rsh);
        half = E_W'(1) << rsh >> 1;
        // ties: away from zero keys on the sign, half-to-even on the kept LSB
        inc = rnd_mode != RND_FLOOR && !shift1_q[SHIFT_W-1] && |shift1_q &&
              (frac > half || (frac == half && (rnd_mode == RND_EVEN ? shr[0] : !ext[E_W-1])));
        rnd = shift1_q[SHIFT_W-1] ? ext <<< lsh : shr + E_W'(inc);
        sum = S_W'(rnd) + S_W'(base1_q);
        fits = &sum[S_W-1:OUT_W-1] || ~|sum[S_W-1:OUT_W-1];
    end

    always_ff @(posedge autosa_core_clk) begin
        if (en0) begin
            sub_q <= SUB_W'(x1) - SUB_W'(x0);
            scale_q <= scale;
            base0_q <= base;
            shift0_q <= shift;
        end
        if (en1) begin
            mul_q <= M_W'(sub_q) * M_W'(scale_q);
            base1_q <= base0_q;
            shift1_q <= shift0_q;
        end
    end

    always_ff @(posedge autosa_core_clk) begin
        if (autosa_core_rst) begin
            out_pd <= '0;
            out_sat <= 1'b0;
        end else if (en2) begin
            out_pd <= fits ? sum[OUT_W-1:0] : sum[S_W-1] ? MINV[OUT_W-1:0] : MAXV[OUT_W-1:0];
            out_sat <= !fits;
        end
    end
endmodule

// File: rtl/cdp_intp_lanes.sv
// cdp_intp_lanes: multi-lane linear interpolation with a 3-stage valid/ready pipeline
module cdp_intp_lanes
    import cdp_intp_pkg::*;
#(
    parameter int LANES   = 1,
    parameter int DATA_W  = 39,
    parameter int SCALE_W = 17,
    parameter int SHIFT_W = 6,
    parameter int BASE_W  = 17,
    parameter int OUT_W   = 16,
    parameter int CNT_W   = 32
) (
    input  logic                       autosa_core_clk,
    input  logic                       autosa_core_rst,
    input  logic                       in_vld,
    output logic                       in_rdy,
    input  logic [LANES*DATA_W-1:0]    in_x0_pd,
    input  logic [LANES*DATA_W-1:0]    in_x1_pd,
    input  logic [LANES*BASE_W-1:0]    in_base_pd,
    input  logic [LANES*SCALE_W-1:0]   in_scale,
    input  logic [LANES*SHIFT_W-1:0]   in_shift,
    input  logic [1:0]                 in_rnd_mode,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [LANES*OUT_W-1:0]     out_pd,
    output logic [LANES-1:0]           out_sat,
    output logic [CNT_W-1:0]           sat_cnt,
    input  logic                       sat_cnt_clr
);
    logic vld0, vld1, vld2, rdy0, rdy1, rdy2, en0, en1, en2, xfer;
    logic [1:0] mode0, mode1;
    logic [CNT_W:0] inc, nxt;

    assign rdy2 = !vld2 || out_rdy;
    assign rdy1 = !vld1 || rdy2;
    assign rdy0 = !vld0 || rdy1;
    assign en0 = in_vld && rdy0;
    assign en1 = vld0 && rdy1;
    assign en2 = vld1 && rdy2;
    assign in_rdy = rdy0;
    assign out_vld = vld2;
    assign xfer = vld2 && out_rdy;

    always_comb begin
        inc = '0;
        for (int i = 0; i < LANES; i++) inc = inc + (CNT_W+1)'(out_sat[i]);
        nxt = (CNT_W+1)'(sat_cnt) + inc;
    end

    always_ff @(posedge autosa_core_clk) begin
        if (autosa_core_rst) begin
            vld0 <= 1'b0;
            vld1 <= 1'b0;
            vld2 <= 1'b0;
            sat_cnt <= '0;
        end else begin
            if (rdy0) vld0 <= in_vld;
            if (rdy1) vld1 <= vld0;
            if (rdy2) vld2 <= vld1;
            // a clear wins over that cycle's events; a carry out pins the count at all-ones
            sat_cnt <= sat_cnt_clr ? '0 : !xfer ? sat_cnt : nxt[CNT_W] ? '1 : nxt[CNT_W-1:0];
        end
    end

    always_ff @(posedge autosa_core_clk) begin
        if (en0) mode0 <= in_rnd_mode;
        if (en1) mode1 <= mode0;
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        cdp_intp_lane_dp #(
            .DATA_W(DATA_W), .SCALE_W(SCALE_W), .SHIFT_W(SHIFT_W), .BASE_W(BASE_W), .OUT_W(OUT_W)
        ) u_dp (
            .autosa_core_clk(autosa_core_clk),
            .autosa_core_rst(autosa_core_rst),
            .en0(en0),
            .en1(en1),
            .en2(en2),
            .x0(in_x0_pd[l*DATA_W +: DATA_W]),
            .x1(in_x1_pd[l*DATA_W +: DATA_W]),
            .base(in_base_pd[l*BASE_W +: BASE_W]),
            .scale(in_scale[l*SCALE_W +: SCALE_W]),
            .shift(in_shift[l*SHIFT_W +: SHIFT_W]),
            .rnd_mode(mode1),
            .out_pd(out_pd[l*OUT_W +: OUT_W]),
            .out_sat(out_sat[l])
        );
    end
endmodule
